// File: rtl/ecp3_perr_pkg.sv
// Shared definitions for the ECP3 parity-error collector: FSM encoding,
// counter limits and the first-error priority helper.
package ecp3_perr_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNTW_DEF  = 8;
  localparam logic [CNTW_DEF-1:0] CNT_SAT = {CNTW_DEF{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    ACKH = 1'b1
  } state_t;

  // Lowest set bit wins; an all-zero word returns 0.
  function automatic logic [3:0] lsb_index(input logic [WIDTH_DEF-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = WIDTH_DEF - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/perr_sat_cnt.sv
// Saturating up-counter with synchronous clear; nxt exposes the value the
// counter would take on this edge if not cleared.
module perr_sat_cnt #(
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            clr,
  input  logic            inc,
  output logic [CNTW-1:0] cnt,
  output logic [CNTW-1:0] nxt
);

  localparam logic [CNTW-1:0] SAT = {CNTW{1'b1}};

  assign nxt = (inc && (cnt != SAT)) ? cnt + CNTW'(1) : cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/perr_collect.sv
// Sticky error collector for the ECP3 16-bit parity-error register, with an
// atomic snapshot-and-clear handed to the host over a four-phase REQ/ACK.
//
// state | meaning
// IDLE  | no request outstanding; REQ high takes a snapshot and clears state
// ACKH  | snapshot presented with ACK high; waits for REQ to fall
module perr_collect
  import ecp3_perr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic [WIDTH-1:0] ERR,
  input  logic             REQ,
  output logic             ACK,
  output logic [WIDTH-1:0] PERR,
  output logic             IRQ,
  output logic [WIDTH-1:0] SNAP,
  output logic [CNTW-1:0]  SCNT,
  output logic [3:0]       SFIRST,
  output logic             SVALID
);

  state_t           state, state_nxt;
  logic             take;
  logic             evt;
  logic [WIDTH-1:0] err_g;
  logic [WIDTH-1:0] sticky;
  logic [3:0]       first;
  logic             fvalid;
  logic [3:0]       first_m;
  logic             fvalid_m;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_nxt;

  assign err_g = EN ? ERR : '0;
  assign evt   = |err_g;

  // Merge the current cycle's event so a snapshot edge never drops it.
  assign first_m  = fvalid ? first : (evt ? lsb_index(err_g) : 4'd0);
  assign fvalid_m = fvalid | evt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (REQ) begin
          take      = 1'b1;
          state_nxt = ACKH;
        end
      end
      ACKH: begin
        if (!REQ) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  perr_sat_cnt #(.CNTW(CNTW)) u_cnt (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (take),
    .inc  (evt),
    .cnt  (cnt),
    .nxt  (cnt_nxt)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sticky <= '0;
      first  <= 4'd0;
      fvalid <= 1'b0;
    end else if (take) begin
      sticky <= '0;
      first  <= 4'd0;
      fvalid <= 1'b0;
    end else begin
      sticky <= sticky | err_g;
      first  <= first_m;
      fvalid <= fvalid_m;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      SNAP   <= '0;
      SCNT   <= '0;
      SFIRST <= 4'd0;
      SVALID <= 1'b0;
    end else if (take) begin
      SNAP   <= sticky | err_g;
      SCNT   <= cnt_nxt;
      SFIRST <= first_m;
      SVALID <= fvalid_m;
    end
  end

  assign ACK  = (state == ACKH);
  assign PERR = sticky;
  assign IRQ  = |sticky;

endmodule

// File: tb/tb_perr_collect.sv
// Directed bench for perr_collect: reset, accumulation, snapshot timing,
// saturation, enable gating and reset during a handshake.
module tb_perr_collect;

  logic        CLK;
  logic        RSTN;
  logic        EN;
  logic [15:0] ERR;
  logic        REQ;
  logic        ACK;
  logic [15:0] PERR;
  logic        IRQ;
  logic [15:0] SNAP;
  logic [7:0]  SCNT;
  logic [3:0]  SFIRST;
  logic        SVALID;

  int ncheck = 0;
  int nfail  = 0;

  perr_collect dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .EN     (EN),
    .ERR    (ERR),
    .REQ    (REQ),
    .ACK    (ACK),
    .PERR   (PERR),
    .IRQ    (IRQ),
    .SNAP   (SNAP),
    .SCNT   (SCNT),
    .SFIRST (SFIRST),
    .SVALID (SVALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncheck++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RSTN = 1'b0;
    EN   = 1'b1;
    ERR  = 16'hFFFF;
    REQ  = 1'b0;
    repeat (2) tick();
    check("rst_perr", PERR, 16'h0000);
    check("rst_irq", {15'd0, IRQ}, 16'd0);
    check("rst_ack", {15'd0, ACK}, 16'd0);
    check("rst_snap", SNAP, 16'h0000);
    check("rst_scnt", {8'd0, SCNT}, 16'd0);

    RSTN = 1'b1;
    ERR  = 16'h0000;
    tick();
    check("idle_perr", PERR, 16'h0000);
    check("idle_irq", {15'd0, IRQ}, 16'd0);
    check("idle_ack", {15'd0, ACK}, 16'd0);

    // accumulate three pulses
    ERR = 16'h0004; tick();
    check("lat_perr", PERR, 16'h0004);
    check("lat_irq", {15'd0, IRQ}, 16'd1);
    ERR = 16'h0100; tick();
    ERR = 16'h0005; tick();
    ERR = 16'h0000;
    check("acc_perr", PERR, 16'h0105);
    REQ = 1'b1; tick();
    check("snap1_ack", {15'd0, ACK}, 16'd1);
    check("snap1_snap", SNAP, 16'h0105);
    check("snap1_scnt", {8'd0, SCNT}, 16'd3);
    check("snap1_first", {12'd0, SFIRST}, 16'd2);
    check("snap1_valid", {15'd0, SVALID}, 16'd1);
    check("snap1_perr", PERR, 16'h0000);
    check("snap1_irq", {15'd0, IRQ}, 16'd0);
    REQ = 1'b0; tick();
    check("rel1_ack", {15'd0, ACK}, 16'd0);
    check("rel1_snap", SNAP, 16'h0105);

    // event in the same cycle as the snapshot
    ERR = 16'h0001; tick();
    ERR = 16'h8000; REQ = 1'b1; tick();
    check("sim_ack", {15'd0, ACK}, 16'd1);
    check("sim_snap", SNAP, 16'h8001);
    check("sim_scnt", {8'd0, SCNT}, 16'd2);
    check("sim_first", {12'd0, SFIRST}, 16'd0);
    check("sim_perr", PERR, 16'h0000);
    ERR = 16'h0010; tick();
    check("ackh_perr", PERR, 16'h0010);
    check("ackh_snap", SNAP, 16'h8001);
    check("ackh_ack", {15'd0, ACK}, 16'd1);
    ERR = 16'h0000; REQ = 1'b0; tick();
    check("rel2_ack", {15'd0, ACK}, 16'd0);
    REQ = 1'b1; tick();
    check("ackh_evt_snap", SNAP, 16'h0010);
    check("ackh_evt_scnt", {8'd0, SCNT}, 16'd1);
    check("ackh_evt_first", {12'd0, SFIRST}, 16'd4);
    REQ = 1'b0; tick();

    // saturation: 300 event cycles
    ERR = 16'h0040; tick();
    ERR = 16'h0008;
    repeat (299) tick();
    ERR = 16'h0000;
    REQ = 1'b1; tick();
    check("sat_scnt", {8'd0, SCNT}, 16'd255);
    check("sat_first", {12'd0, SFIRST}, 16'd6);
    check("sat_snap", SNAP, 16'h0048);
    REQ = 1'b0; tick();

    // enable gating
    EN = 1'b0; ERR = 16'hFFFF;
    repeat (5) tick();
    check("gate_perr", PERR, 16'h0000);
    REQ = 1'b1; tick();
    check("gate_snap", SNAP, 16'h0000);
    check("gate_scnt", {8'd0, SCNT}, 16'd0);
    check("gate_valid", {15'd0, SVALID}, 16'd0);
    check("gate_first", {12'd0, SFIRST}, 16'd0);
    REQ = 1'b0; tick();

    // EN low in the snapshot cycle keeps only prior sticky state
    EN = 1'b1; ERR = 16'h0002; tick();
    EN = 1'b0; ERR = 16'hFFFF; REQ = 1'b1; tick();
    check("en0_snap", SNAP, 16'h0002);
    check("en0_scnt", {8'd0, SCNT}, 16'd1);
    check("en0_first", {12'd0, SFIRST}, 16'd1);
    REQ = 1'b0; EN = 1'b1; ERR = 16'h0000; tick();

    // reset in the middle of a handshake
    ERR = 16'h0200; tick();
    ERR = 16'h0000; REQ = 1'b1; tick();
    check("mid_ack_pre", {15'd0, ACK}, 16'd1);
    check("mid_snap_pre", SNAP, 16'h0200);
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    check("mid_ack", {15'd0, ACK}, 16'd0);
    check("mid_snap", SNAP, 16'h0000);
    check("mid_perr", PERR, 16'h0000);
    tick();
    RSTN = 1'b1;
    tick();
    check("restart_ack", {15'd0, ACK}, 16'd1);
    check("restart_snap", SNAP, 16'h0000);
    check("restart_valid", {15'd0, SVALID}, 16'd0);
    REQ = 1'b0; tick();
    check("restart_rel", {15'd0, ACK}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
